uart_tx_serializer: RTL and testbench
=====================================

# uart_tx_serializer

Byte-stream UART transmitter that sits directly downstream of the SoC's UART MMIO write port. It turns single-cycle byte writes into 8N1 serial frames on `tx_serial`, buffering writes in a small FIFO so back-to-back stores are not lost. It also produces a per-byte completion pulse that the Verilator bench observes.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit. Legal range 2..65535.
- `FIFO_DEPTH`, default 8: FIFO entries. Must be a power of 2, at least 2.

Ports:
- `clk` in 1: single clock; all state updates on posedge.
- `rst` in 1: synchronous, active-high reset.
- `wr_en` in 1: byte write strobe from the MMIO decode; one byte per asserted cycle.
- `wr_data` in 8: byte to transmit.
- `full` out 1: FIFO holds `FIFO_DEPTH` entries; registered.
- `empty` out 1: FIFO holds 0 entries; registered.
- `level` out $clog2(FIFO_DEPTH)+1: current FIFO occupancy.
- `busy` out 1: FSM is not IDLE.
- `ovf` out 1: sticky overflow flag (a write was dropped).
- `ovf_clr` in 1: clears `ovf`.
- `tx_serial` out 1: serial line; idles high.
- `byte_done` out 1: one-cycle pulse when a frame's stop bit completes.
- `byte_done_data` out 8: the byte whose frame just completed; holds its value until the next pulse.

## Operation
- FIFO write:
  - `wr_en` && !`full`: push `wr_data`.
  - `wr_en` && `full`: byte dropped and `ovf` set. This holds even if a pop occurs in the same cycle, because `full` is evaluated on registered occupancy.
- FIFO pop: only the FSM pops, and only when `level != 0`.
  - Simultaneous push and pop leaves `level` unchanged.
  - Pointers wrap modulo `FIFO_DEPTH`.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: `tx_serial`=1. If !`empty`, pop into `shift_q` and go to START.
  - START: `tx_serial`=0 for `CLKS_PER_BIT` cycles, then go to DATA with `bit_idx`=0.
  - DATA: `tx_serial`=`shift_q[0]`, LSB first. Each bit is held `CLKS_PER_BIT` cycles, then the register shifts right and `bit_idx` increments. After bit 7, go to STOP.
  - STOP: `tx_serial`=1 for `CLKS_PER_BIT` cycles. On exit, pulse `byte_done` and load `byte_done_data`. Then:
    - if !`empty`: pop and go straight to START, with no idle gap;
    - else: go to IDLE.
- Baud counter:
  - Width $clog2(CLKS_PER_BIT).
  - Reloads to 0 on every state or bit transition.
  - Terminal count is `CLKS_PER_BIT-1`.
- `ovf` priority: a set and an `ovf_clr` in the same cycle resolve to set.
- `busy` = (state != IDLE).

## Timing
- Reset values:
  - `tx_serial`=1, `full`=0, `empty`=1, `level`=0, `busy`=0.
  - `ovf`=0, `byte_done`=0, `byte_done_data`=0x00.
  - FSM in IDLE, pointers and counters at 0.
- Reset mid-frame: at the reset edge, `tx_serial` returns to 1 and the FIFO is emptied. The frame is truncated and no `byte_done` is issued.
- Write latency: `wr_en` sampled at edge E gives `level` and `empty` updated after E.
  - With the FSM in IDLE, the pop occurs at edge E+1, and `tx_serial`=0 is registered from E+1.
- Frame length: exactly 10×`CLKS_PER_BIT` cycles, start to end of stop bit.
- `byte_done` is high for one cycle, registered at edge E+1+10×`CLKS_PER_BIT` for a byte written at E into an idle, empty block.
- Back-to-back frames are contiguous: the next start bit begins on the same edge that `byte_done` rises.
- `tx_serial` is driven from a flop (glitch-free).

## Structure
- `z32u_pkg` gains:
  - `typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} uart_tx_state_t`;
  - `localparam int UART_CLKS_PER_BIT_DEFAULT = 16`.
- Sub-module `sync_fifo`, parameterised by width and depth, with registered `full`, `empty` and `level`. It is reusable for a future RX path.
- The serializer FSM, baud counter and shift register live in `uart_tx_serializer`.

## Test plan
Benches run with `CLKS_PER_BIT`=4 and `FIFO_DEPTH`=4 unless stated.
- Single byte: write 0x55 at edge 0 → `tx_serial` 0 on edges 1–4, then bits 1,0,1,0,1,0,1,0 (4 cycles each), then 1 for 4 cycles. `byte_done`=1 at edge 41 with `byte_done_data`=0x55; `busy` falls the same edge.
- Back-to-back: write 0xA3 and 0x0F on consecutive cycles → two contiguous 40-cycle frames with no idle gap. `byte_done` pulses 40 cycles apart with data 0xA3 then 0x0F.
- Overflow: 6 writes on consecutive cycles (0x01..0x06) while idle.
  - First pop frees one slot, so 0x01..0x05 are transmitted and 0x06 is dropped.
  - `ovf`=1 and stays set until `ovf_clr`.
  - Asserting `ovf_clr` together with a dropped write leaves `ovf`=1.
- Full with concurrent pop: with `level`=4 at the cycle the STOP state pops, a write in that cycle is dropped, `ovf`=1 and `level`=3 after.
- Reset mid-frame: assert `rst` during bit 3 of 0xFF with 2 bytes queued → next edge gives `tx_serial`=1, `empty`=1, `level`=0, `busy`=0. No `byte_done` occurs and nothing transmits afterwards.
- Wrap-around: 12 bytes written in 3 bursts of 4 with `FIFO_DEPTH`=4 → all 12 `byte_done_data` values arrive in order and `ovf` stays 0.

Source files
------------

// File: rtl/z32u_pkg.sv
// z32u_pkg: shared types and constants for the z32u UART blocks.
//   uart_tx_state_t           - transmitter FSM state encoding
//   UART_CLKS_PER_BIT_DEFAULT - default clocks per serial bit
//   UART_DATA_BITS            - data bits per 8N1 frame
package z32u_pkg;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } uart_tx_state_t;

  localparam int UART_CLKS_PER_BIT_DEFAULT = 16;
  localparam int UART_DATA_BITS            = 8;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered occupancy flags.
//   clk, rst       - clock, synchronous active-high reset
//   wr_en, wr_data - push strobe and data; ignored while full
//   rd_en, rd_data - pop strobe; rd_data shows the head entry (valid when !empty)
//   full, empty    - registered occupancy flags
//   level          - registered entry count, 0..DEPTH
//   drop           - a write was presented while full (combinational)
// DEPTH must be a power of two (pointers wrap by natural overflow).
module sync_fifo
  import z32u_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     drop
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic             r_full;
  logic             r_empty;

  logic             w_push;
  logic             w_pop;
  logic [AW:0]      w_level_next;

  // Acceptance is decided on registered flags only, so a pop in the same
  // cycle never makes room for a write presented while full.
  assign w_push       = wr_en && !r_full;
  assign w_pop        = rd_en && !r_empty;
  assign w_level_next = r_level + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_level <= w_level_next;
      r_full  <= (w_level_next == LVL_FULL);
      r_empty <= (w_level_next == '0);
    end
  end

  assign rd_data = r_mem[r_rd_ptr];
  assign full    = r_full;
  assign empty   = r_empty;
  assign level   = r_level;
  assign drop    = wr_en && r_full;

endmodule

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: buffered 8N1 UART transmitter.
//   clk, rst        - clock, synchronous active-high reset
//   wr_en, wr_data  - byte write strobe and byte
//   full, empty     - FIFO occupancy flags (registered)
//   level           - FIFO occupancy
//   busy            - FSM not idle
//   ovf, ovf_clr    - sticky dropped-write flag and its clear
//   tx_serial       - serial line, idles high, flop-driven
//   byte_done       - one-cycle pulse when a stop bit completes
//   byte_done_data  - byte of the frame that just completed
//   dbg_state       - current FSM state (uart_tx_state_t encoding)
//
// Write interface: wr_en is a fire-and-forget strobe with no back-pressure.
// full is the not-ready indication; a write accepted requires wr_en && !full
// at the same edge, and a write presented while full is dropped and sets ovf.
module uart_tx_serializer
  import z32u_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [7:0]                    wr_data,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          busy,
  output logic                          ovf,
  input  logic                          ovf_clr,
  output logic                          tx_serial,
  output logic                          byte_done,
  output logic [7:0]                    byte_done_data,
  output logic [1:0]                    dbg_state
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_TC = CW'(CLKS_PER_BIT - 1);

  uart_tx_state_t r_state;
  logic [CW-1:0]  r_baud;
  logic [2:0]     r_bit_idx;
  logic [7:0]     r_shift;
  logic [7:0]     r_cur;
  logic           r_tx;
  logic           r_done;
  logic [7:0]     r_done_data;
  logic           r_ovf;

  logic [7:0]     w_rd_data;
  logic           w_pop;
  logic           w_drop;
  logic           w_baud_tc;

  assign w_baud_tc = (r_baud == BAUD_TC);

  // Pop when idle, or at the last cycle of a stop bit so the next start bit
  // follows with no idle gap.
  assign w_pop = !empty &&
                 ((r_state == TX_IDLE) || ((r_state == TX_STOP) && w_baud_tc));

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (w_pop),
    .rd_data (w_rd_data),
    .full    (full),
    .empty   (empty),
    .level   (level),
    .drop    (w_drop)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= TX_IDLE;
      r_baud      <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_cur       <= '0;
      r_tx        <= 1'b1;
      r_done      <= 1'b0;
      r_done_data <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        TX_IDLE: begin
          r_tx   <= 1'b1;
          r_baud <= '0;
          if (w_pop) begin
            r_shift <= w_rd_data;
            r_cur   <= w_rd_data;
            r_tx    <= 1'b0;
            r_state <= TX_START;
          end
        end
        TX_START: begin
          if (w_baud_tc) begin
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_tx      <= r_shift[0];
            r_state   <= TX_DATA;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        TX_DATA: begin
          if (w_baud_tc) begin
            r_baud <= '0;
            if (r_bit_idx == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= TX_STOP;
            end else begin
              // r_shift[1] is the bit that becomes LSB after this shift.
              r_shift   <= {1'b0, r_shift[7:1]};
              r_tx      <= r_shift[1];
              r_bit_idx <= r_bit_idx + 1'b1;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        TX_STOP: begin
          if (w_baud_tc) begin
            r_baud      <= '0;
            r_done      <= 1'b1;
            r_done_data <= r_cur;
            if (w_pop) begin
              r_shift <= w_rd_data;
              r_cur   <= w_rd_data;
              r_tx    <= 1'b0;
              r_state <= TX_START;
            end else begin
              r_tx    <= 1'b1;
              r_state <= TX_IDLE;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_baud  <= '0;
          r_state <= TX_IDLE;
        end
      endcase
    end
  end

  // A drop and a clear in the same cycle resolve to set.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end else if (ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

  assign busy           = (r_state != TX_IDLE);
  assign ovf            = r_ovf;
  assign tx_serial      = r_tx;
  assign byte_done      = r_done;
  assign byte_done_data = r_done_data;
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_uart_tx_serializer.sv
module tb_uart_tx_serializer;
  import z32u_pkg::*;

  localparam int C  = 4;
  localparam int D  = 4;
  localparam int LW = $clog2(D) + 1;
  localparam int FRAME = 10 * C;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [7:0]    wr_data = 8'h00;
  logic          ovf_clr = 1'b0;
  logic          full, empty, busy, ovf, tx_serial, byte_done;
  logic [LW-1:0] level;
  logic [7:0]    byte_done_data;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  uart_tx_serializer #(
    .CLKS_PER_BIT (C),
    .FIFO_DEPTH   (D)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .wr_en          (wr_en),
    .wr_data        (wr_data),
    .full           (full),
    .empty          (empty),
    .level          (level),
    .busy           (busy),
    .ovf            (ovf),
    .ovf_clr        (ovf_clr),
    .tx_serial      (tx_serial),
    .byte_done      (byte_done),
    .byte_done_data (byte_done_data),
    .dbg_state      (dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  bit         chk_en   = 1'b0;
  logic [7:0] exp_q[$];
  int         done_cyc[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A queue of accepted bytes, plus the byte on the wire and the cycle
  // offset into its 10*C-cycle frame.
  logic [7:0] m_q[$];
  bit         m_active    = 1'b0;
  int         m_pos       = 0;
  logic [7:0] m_cur       = 8'h00;
  bit         m_ovf       = 1'b0;
  bit         m_done      = 1'b0;
  logic [7:0] m_done_data = 8'h00;
  bit         m_full_pre;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_q.delete();
      exp_q.delete();
      m_active    = 1'b0;
      m_pos       = 0;
      m_ovf       = 1'b0;
      m_done      = 1'b0;
      m_done_data = 8'h00;
    end else begin
      m_full_pre = (m_q.size() == D);
      m_done     = 1'b0;
      if (m_active) begin
        if (m_pos == FRAME - 1) begin
          m_done      = 1'b1;
          m_done_data = m_cur;
          if (m_q.size() != 0) begin
            m_cur = m_q.pop_front();
            m_pos = 0;
          end else begin
            m_active = 1'b0;
          end
        end else begin
          m_pos++;
        end
      end else if (m_q.size() != 0) begin
        m_cur    = m_q.pop_front();
        m_pos    = 0;
        m_active = 1'b1;
      end
      if (wr_en && m_full_pre) begin
        m_ovf = 1'b1;
      end else begin
        if (wr_en) begin
          m_q.push_back(wr_data);
          exp_q.push_back(wr_data);
        end
        if (ovf_clr) m_ovf = 1'b0;
      end
    end
  end

  function automatic logic exp_tx();
    int b;
    if (!m_active) return 1'b1;
    b = m_pos / C;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return m_cur[b-1];
  endfunction

  // ---------------- compare process + scoreboard ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("tx_serial", 32'(tx_serial), 32'(exp_tx()));
      check("level", 32'(level), 32'(m_q.size()));
      check("empty", 32'(empty), 32'(m_q.size() == 0));
      check("full", 32'(full), 32'(m_q.size() == D));
      check("busy", 32'(busy), 32'(m_active));
      check("dbg_state_idle", 32'(dbg_state == 2'(TX_IDLE)), 32'(!m_active));
      check("ovf", 32'(ovf), 32'(m_ovf));
      check("byte_done", 32'(byte_done), 32'(m_done));
      check("byte_done_data", 32'(byte_done_data), 32'(m_done_data));
      if (byte_done) begin
        done_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_unexpected: got byte %0h expected no completion (cycle %0d)",
                   byte_done_data, cyc);
        end else begin
          check("sb_data", 32'(byte_done_data), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic write_burst(input logic [7:0] first, input int n, output int e);
    e = 0;
    for (int i = 0; i < n; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'(first + i);
      @(negedge clk);
      if (i == 0) e = cyc;
    end
    wr_en = 1'b0;
  endtask

  task automatic drain(input int max_cycles);
    int i;
    for (i = 0; i < max_cycles; i++) begin
      if (!m_active && m_q.size() == 0) break;
      @(negedge clk);
    end
    if (i == max_cycles) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: got busy after %0d cycles expected idle", max_cycles);
    end
    repeat (2) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int e;
    int n0;

    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("rst_tx", 32'(tx_serial), 32'd1);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_done", 32'(byte_done), 32'd0);
    check("rst_done_data", 32'(byte_done_data), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single byte 0x55: start on edges 1-4, bit0 from edge 5, done at 41.
    write_burst(8'h55, 1, e);
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      if (cyc == e + 1) begin
        check("single_start_tx", 32'(tx_serial), 32'd0);
        check("model_pin_start", 32'(exp_tx()), 32'd0);
      end
      if (cyc == e + 5) check("single_bit0", 32'(tx_serial), 32'd1);
      if (cyc == e + 9) check("single_bit1", 32'(tx_serial), 32'd0);
      if (cyc == e + 37) check("single_stop", 32'(tx_serial), 32'd1);
      if (cyc == e + 40) check("single_no_done_yet", 32'(byte_done), 32'd0);
      if (cyc == e + 41) begin
        check("single_done_at_41", 32'(byte_done), 32'd1);
        check("single_done_data", 32'(byte_done_data), 32'h55);
        check("single_busy_fall", 32'(busy), 32'd0);
      end
    end
    drain(100);

    // Back-to-back: contiguous frames, pulses FRAME cycles apart.
    n0 = done_cyc.size();
    wr_en = 1'b1; wr_data = 8'hA3; @(negedge clk);
    wr_data = 8'h0F; @(negedge clk);
    wr_en = 1'b0;
    drain(200);
    check("b2b_count", 32'(done_cyc.size() - n0), 32'd2);
    if (done_cyc.size() - n0 == 2)
      check("b2b_spacing", 32'(done_cyc[n0+1] - done_cyc[n0]), 32'd40);
    check("b2b_last_data", 32'(byte_done_data), 32'h0F);

    // Overflow: 6 writes while idle; the sixth is dropped.
    n0 = done_cyc.size();
    write_burst(8'h01, 6, e);
    drain(400);
    check("ovf_count", 32'(done_cyc.size() - n0), 32'd5);
    check("ovf_sticky", 32'(ovf), 32'd1);
    check("ovf_last_data", 32'(byte_done_data), 32'h05);
    ovf_clr = 1'b1; @(negedge clk); ovf_clr = 1'b0;
    check("ovf_cleared", 32'(ovf), 32'd0);

    // Clear together with a dropped write resolves to set.
    for (int i = 0; i < 6; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'(8'h21 + i);
      ovf_clr = (i == 5);
      @(negedge clk);
    end
    wr_en = 1'b0; ovf_clr = 1'b0;
    check("ovf_set_beats_clr", 32'(ovf), 32'd1);
    drain(400);
    ovf_clr = 1'b1; @(negedge clk); ovf_clr = 1'b0;

    // Full with concurrent pop: write at the STOP pop edge is dropped.
    write_burst(8'h11, 5, e);
    check("full_level4", 32'(level), 32'd4);
    while (cyc < e + 40) @(negedge clk);
    wr_en = 1'b1; wr_data = 8'hEE; @(negedge clk);
    wr_en = 1'b0;
    check("fullpop_level3", 32'(level), 32'd3);
    check("fullpop_ovf", 32'(ovf), 32'd1);
    drain(400);
    ovf_clr = 1'b1; @(negedge clk); ovf_clr = 1'b0;

    // Reset during bit 3 of 0xFF with two bytes queued.
    write_burst(8'hFF, 1, e);
    wr_en = 1'b1; wr_data = 8'h33; @(negedge clk);
    wr_data = 8'h44; @(negedge clk);
    wr_en = 1'b0;
    while (cyc < e + 18) @(negedge clk);
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    check("midrst_tx", 32'(tx_serial), 32'd1);
    check("midrst_empty", 32'(empty), 32'd1);
    check("midrst_level", 32'(level), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    n0 = done_cyc.size();
    repeat (60) @(negedge clk);
    check("midrst_no_done", 32'(done_cyc.size() - n0), 32'd0);
    check("midrst_line_idle", 32'(tx_serial), 32'd1);

    // Wrap-around: 3 bursts of 4.
    n0 = done_cyc.size();
    for (int b = 0; b < 3; b++) begin
      write_burst(8'(8'h40 + 4 * b), 4, e);
      drain(300);
    end
    check("wrap_count", 32'(done_cyc.size() - n0), 32'd12);
    check("wrap_ovf", 32'(ovf), 32'd0);
    check("wrap_last_data", 32'(byte_done_data), 32'h4B);

    // Random traffic with occasional clears and resets.
    for (int i = 0; i < 3000; i++) begin
      int p;
      p = (i < 1500) ? 3 : 40;
      wr_en   = ($urandom_range(0, 99) < p);
      wr_data = 8'($urandom);
      ovf_clr = ($urandom_range(0, 49) == 0);
      rst     = ($urandom_range(0, 999) == 0);
      @(negedge clk);
    end
    wr_en = 1'b0; ovf_clr = 1'b0; rst = 1'b0;
    drain(400);
    check("final_idle_tx", 32'(tx_serial), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
